// File: rtl/axis_tcm_capture_if.sv
// AXI-Stream handshake bundle feeding axis_tcm_capture.
// The source drives data/valid/last; the capture block answers with TREADY.
interface axis_tcm_capture_if #(
  parameter int C_S_AXIS_TDATA_WIDTH = 32
);
  logic                            TREADY;
  logic [C_S_AXIS_TDATA_WIDTH-1:0] TDATA;
  logic                            TLAST;
  logic                            TVALID;

  modport master (input TREADY, output TDATA, output TLAST, output TVALID);
  modport slave  (output TREADY, input TDATA, input TLAST, input TVALID);
endinterface

// File: rtl/axis_tcm_capture.sv
// Captures one AXI-Stream frame into an inferred TCM BRAM, in one-shot or circular mode.
// Define AXIS_TCM_RD_PIPE_EN to add an output register on the read port (latency 2).
module axis_tcm_capture #(
  parameter int C_S_AXIS_TDATA_WIDTH = 32,
  parameter int C_TCM_ADDR_WIDTH     = 5
) (
  input  logic                            S_AXIS_ACLK,
  input  logic                            S_AXIS_ARESETN,
  axis_tcm_capture_if.slave               S_AXIS,
  input  logic                            USR_cap_en,
  input  logic                            USR_cap_mode,
  input  logic                            USR_clear,
  input  logic                            USR_rd_en,
  input  logic [C_TCM_ADDR_WIDTH-1:0]     USR_rd_addr,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0] USR_rd_data,
  output logic                            USR_rd_valid,
  output logic [C_TCM_ADDR_WIDTH:0]       USR_wr_count,
  output logic [C_TCM_ADDR_WIDTH-1:0]     USR_wr_ptr,
  output logic                            USR_busy,
  output logic                            USR_done,
  output logic                            USR_trunc,
  output logic                            USR_wrapped
);
  localparam int DW    = C_S_AXIS_TDATA_WIDTH;
  localparam int AW    = C_TCM_ADDR_WIDTH;
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] CNT_FULL = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] CNT_LAST = {1'b0, {AW{1'b1}}};

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

  state_t          state_q, state_d;
  logic            tready_q, tready_d;
  logic            mode_q, mode_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]     wr_count_q, wr_count_d;
  logic            done_q, done_d;
  logic            trunc_q, trunc_d;
  logic            wrapped_q, wrapped_d;
  logic [DW-1:0]   rd_data_q, rd_data_d;
  logic            rd_valid_q, rd_valid_d;
  logic [DW-1:0]   mem [DEPTH];
  logic [DW-1:0]   rd_word;
  logic            beat;
  logic            wr_en;
  logic            frame_end;
  logic            frame_full;

  assign beat       = S_AXIS.TVALID & tready_q;
  assign wr_en      = beat & ~USR_clear & S_AXIS_ARESETN;
  assign frame_end  = beat & S_AXIS.TLAST;
  assign frame_full = beat & ~S_AXIS.TLAST & ~mode_q & (wr_count_q == CNT_LAST);
  assign rd_word    = mem[USR_rd_addr];

  always_ff @(posedge S_AXIS_ACLK) begin
    if (!S_AXIS_ARESETN) state_q <= IDLE;
    else                 state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (USR_clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (USR_cap_en) state_d = CAPTURE;
        CAPTURE: begin
          if (!USR_cap_en)                  state_d = IDLE;
          else if (frame_end || frame_full) state_d = DONE;
        end
        DONE:    if (!USR_cap_en) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Status and write-pointer bookkeeping; a dropped cap_en still takes its beat.
  always_comb begin
    tready_d   = (state_d == CAPTURE);
    mode_d     = mode_q;
    wr_ptr_d   = wr_ptr_q;
    wr_count_d = wr_count_q;
    done_d     = done_q;
    trunc_d    = trunc_q;
    wrapped_d  = wrapped_q;
    if (USR_clear) begin
      wr_ptr_d   = '0;
      wr_count_d = '0;
      done_d     = 1'b0;
      trunc_d    = 1'b0;
      wrapped_d  = 1'b0;
    end else if (state_q == IDLE && USR_cap_en) begin
      mode_d     = USR_cap_mode;
      wr_ptr_d   = '0;
      wr_count_d = '0;
      done_d     = 1'b0;
      trunc_d    = 1'b0;
      wrapped_d  = 1'b0;
    end else if (state_q == CAPTURE && beat) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (wr_count_q != CNT_FULL) wr_count_d = wr_count_q + 1'b1;
      if (mode_q && wr_count_q == CNT_FULL) wrapped_d = 1'b1;
      if (USR_cap_en && frame_end) done_d = 1'b1;
      if (USR_cap_en && frame_full) begin
        done_d  = 1'b1;
        trunc_d = 1'b1;
      end
    end
  end

  always_ff @(posedge S_AXIS_ACLK) begin
    if (wr_en) mem[wr_ptr_q] <= S_AXIS.TDATA;
  end

`ifdef AXIS_TCM_RD_PIPE_EN
  logic [DW-1:0] rd_pipe_data_q, rd_pipe_data_d;
  logic          rd_pipe_vld_q;

  always_comb begin
    rd_pipe_data_d = USR_rd_en ? rd_word : rd_pipe_data_q;
    rd_data_d      = rd_pipe_vld_q ? rd_pipe_data_q : rd_data_q;
    rd_valid_d     = rd_pipe_vld_q;
  end

  always_ff @(posedge S_AXIS_ACLK) begin
    rd_pipe_data_q <= rd_pipe_data_d;
    if (!S_AXIS_ARESETN) rd_pipe_vld_q <= 1'b0;
    else                 rd_pipe_vld_q <= USR_rd_en;
  end
`else
  always_comb begin
    rd_data_d  = USR_rd_en ? rd_word : rd_data_q;
    rd_valid_d = USR_rd_en;
  end
`endif

  always_ff @(posedge S_AXIS_ACLK) begin
    if (!S_AXIS_ARESETN) begin
      tready_q   <= 1'b0;
      mode_q     <= 1'b0;
      wr_ptr_q   <= '0;
      wr_count_q <= '0;
      done_q     <= 1'b0;
      trunc_q    <= 1'b0;
      wrapped_q  <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      tready_q   <= tready_d;
      mode_q     <= mode_d;
      wr_ptr_q   <= wr_ptr_d;
      wr_count_q <= wr_count_d;
      done_q     <= done_d;
      trunc_q    <= trunc_d;
      wrapped_q  <= wrapped_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign S_AXIS.TREADY = tready_q;
  assign USR_rd_data   = rd_data_q;
  assign USR_rd_valid  = rd_valid_q;
  assign USR_wr_count  = wr_count_q;
  assign USR_wr_ptr    = wr_ptr_q;
  assign USR_busy      = (state_q == CAPTURE);
  assign USR_done      = done_q;
  assign USR_trunc     = trunc_q;
  assign USR_wrapped   = wrapped_q;
endmodule

// File: tb/tb_axis_tcm_capture.sv
// Randomized bench for axis_tcm_capture against a frame-level reference model.
// Build with AXIS_TCM_RD_PIPE_EN to exercise the two-cycle read path.
module tb_axis_tcm_capture;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;
`ifdef AXIS_TCM_RD_PIPE_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          cap_en, cap_mode, clear, rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid, busy, done, trunc, wrapped;
  logic [AW:0]   wr_count;
  logic [AW-1:0] wr_ptr;

  axis_tcm_capture_if #(.C_S_AXIS_TDATA_WIDTH(DW)) axis ();

  axis_tcm_capture #(.C_S_AXIS_TDATA_WIDTH(DW), .C_TCM_ADDR_WIDTH(AW)) dut (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(rstn), .S_AXIS(axis),
    .USR_cap_en(cap_en), .USR_cap_mode(cap_mode), .USR_clear(clear),
    .USR_rd_en(rd_en), .USR_rd_addr(rd_addr), .USR_rd_data(rd_data),
    .USR_rd_valid(rd_valid), .USR_wr_count(wr_count), .USR_wr_ptr(wr_ptr),
    .USR_busy(busy), .USR_done(done), .USR_trunc(trunc), .USR_wrapped(wrapped)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_now  = 0;

  // Reference model: capture session (0 idle, 1 capturing, 2 finished), memory image, read queue
  int            m_st = 0;
  bit            m_mode;
  int            m_cnt = 0, m_ptr = 0;
  bit            m_done, m_trunc, m_wrap;
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_known [DEPTH];
  bit            e1_v, e1_k, ev, ek;
  logic [DW-1:0] e1_d, ed;
  logic [DW-1:0] rd_seen[$];
  int            rd_seen_cyc[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [DW-1:0] rv;
    bit rk, beat;
    rv   = m_mem[rd_addr];
    rk   = m_known[rd_addr];
    beat = axis.TVALID && (m_st == 1);
    if (!rstn) begin
      m_st = 0; m_cnt = 0; m_ptr = 0; m_done = 0; m_trunc = 0; m_wrap = 0;
      e1_v = 0; ev = 0; ed = '0; ek = 1;
    end else begin
      if (RD_LAT == 2) begin
        ev = e1_v;
        if (e1_v) begin ed = e1_d; ek = e1_k; end
        e1_v = rd_en;
        if (rd_en) begin e1_d = rv; e1_k = rk; end
      end else begin
        ev = rd_en;
        if (rd_en) begin ed = rv; ek = rk; end
      end
      if (clear) begin
        m_st = 0; m_cnt = 0; m_ptr = 0; m_done = 0; m_trunc = 0; m_wrap = 0;
      end else if (m_st == 0) begin
        if (cap_en) begin
          m_st = 1; m_mode = cap_mode;
          m_cnt = 0; m_ptr = 0; m_done = 0; m_trunc = 0; m_wrap = 0;
        end
      end else if (m_st == 1) begin
        if (beat) begin
          m_mem[m_ptr] = axis.TDATA;
          m_known[m_ptr] = 1;
          if (m_mode && m_cnt == DEPTH) m_wrap = 1;
          m_ptr = (m_ptr + 1) % DEPTH;
          if (m_cnt < DEPTH) m_cnt++;
        end
        if (!cap_en) m_st = 0;
        else if (beat && axis.TLAST) begin m_st = 2; m_done = 1; end
        else if (beat && !m_mode && m_cnt == DEPTH) begin m_st = 2; m_done = 1; m_trunc = 1; end
      end else if (!cap_en) begin
        m_st = 0;
      end
    end
  endtask

  task automatic check_all();
    check_eq("tready", axis.TREADY, (m_st == 1));
    check_eq("busy", busy, (m_st == 1));
    check_eq("done", done, m_done);
    check_eq("trunc", trunc, m_trunc);
    check_eq("wrapped", wrapped, m_wrap);
    check_eq("wr_count", wr_count, m_cnt);
    check_eq("wr_ptr", wr_ptr, m_ptr);
    check_eq("rd_valid", rd_valid, ev);
    if (ek) check_eq("rd_data", rd_data, ed);
    if (rd_valid === 1'b1) begin
      rd_seen.push_back(rd_data);
      rd_seen_cyc.push_back(cyc_now);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    cyc_now++;
    check_all();
  endtask

  task automatic arm(input bit mode);
    cap_en = 1; cap_mode = mode; clear = 0;
    axis.TVALID = 0; axis.TLAST = 0;
    tick();
    cap_mode = 1'($urandom_range(0, 1));
  endtask

  task automatic send_frame(input int n, input int last_idx, input bit rnd_valid,
                            input bit rnd_data, input logic [DW-1:0] base,
                            input bit follow_rd, input bit rnd_ctl);
    int i, cyc;
    i = 0; cyc = 0;
    while (i < n && m_st == 1 && cyc < 500) begin
      axis.TVALID = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      axis.TDATA  = rnd_data ? DW'($urandom) : base + DW'(i);
      axis.TLAST  = (i == last_idx);
      rd_en       = 1'($urandom_range(0, 1));
      rd_addr     = follow_rd ? AW'(m_ptr) : AW'($urandom_range(0, DEPTH - 1));
      clear       = rnd_ctl && ($urandom_range(0, 40) == 0);
      cap_en      = rnd_ctl ? ($urandom_range(0, 40) != 0) : 1'b1;
      if (axis.TVALID && m_st == 1) i++;
      tick();
      cyc++;
    end
    if (cyc >= 500) check_eq("frame_timeout", i, n);
    clear = 0; rd_en = 0; axis.TLAST = 0;
    if (m_st != 1) begin
      axis.TVALID = 1; axis.TDATA = 32'hDEAD_BEEF;
      tick(); tick();
    end
    axis.TVALID = 0;
  endtask

  task automatic rd_check(input string tag, input int addr, input logic [DW-1:0] exp);
    int start;
    rd_seen.delete(); rd_seen_cyc.delete();
    axis.TVALID = 0;
    rd_en = 1; rd_addr = AW'(addr);
    start = cyc_now;
    tick();
    rd_en = 0;
    for (int k = 0; k < 4 && rd_seen.size() == 0; k++) tick();
    check_eq({tag, "_cnt"}, rd_seen.size(), 1);
    if (rd_seen.size() > 0) begin
      check_eq(tag, rd_seen[0], exp);
      check_eq({tag, "_lat"}, rd_seen_cyc[0] - start, RD_LAT);
    end
  endtask

  task automatic idle_off();
    cap_en = 0; axis.TVALID = 0;
    tick();
  endtask

  initial begin
    cap_en = 0; cap_mode = 0; clear = 0; rd_en = 0; rd_addr = '0;
    axis.TVALID = 0; axis.TDATA = '0; axis.TLAST = 0;
    for (int k = 0; k < DEPTH; k++) m_known[k] = 0;
    tick(); tick();
    check_eq("rst_rd_data", rd_data, 0);
    check_eq("rst_count", wr_count, 0);
    rstn = 1;
    tick();

    // One-shot, no TLAST: truncation at full
    arm(0);
    send_frame(40, -1, 0, 0, 32'h1000, 0, 0);
    check_eq("full_done", done, 1);
    check_eq("full_trunc", trunc, 1);
    check_eq("full_count", wr_count, 32);
    rd_check("full_a31", 31, 32'h1000 + 31);
    idle_off();

    // One-shot, 4 beats with TLAST
    arm(0);
    send_frame(4, 3, 0, 0, 32'hA0, 0, 0);
    check_eq("f4_done", done, 1);
    check_eq("f4_trunc", trunc, 0);
    check_eq("f4_count", wr_count, 4);
    check_eq("f4_tready", axis.TREADY, 0);
    for (int a = 0; a < 4; a++) rd_check("f4_rd", a, 32'hA0 + a);
    idle_off();

    // Circular, 40 beats, TLAST on the last
    arm(1);
    send_frame(40, 39, 0, 0, 32'h0, 0, 0);
    check_eq("circ_wrap", wrapped, 1);
    check_eq("circ_count", wr_count, 32);
    check_eq("circ_ptr", wr_ptr, 8);
    rd_check("circ_a7", 7, 39);
    rd_check("circ_a8", 8, 8);
    idle_off();
    check_eq("idle_keep_done", done, 1);

    // TVALID toggling
    arm(0);
    for (int k = 0; k < 6; k++) begin
      axis.TVALID = (k % 2 == 0);
      axis.TDATA  = (k % 2 == 0) ? 32'h11 * (k / 2 + 1) : 32'hDEAD;
      axis.TLAST  = (k == 4);
      tick();
    end
    axis.TVALID = 0; axis.TLAST = 0;
    rd_check("tog_a0", 0, 32'h11);
    rd_check("tog_a1", 1, 32'h22);
    rd_check("tog_a2", 2, 32'h33);
    idle_off();

    // Abort, re-arm, reset during a beat
    arm(0);
    send_frame(5, -1, 0, 0, 32'hB0, 0, 0);
    idle_off();
    check_eq("abort_tready", axis.TREADY, 0);
    check_eq("abort_count", wr_count, 5);
    arm(0);
    check_eq("rearm_count", wr_count, 0);
    send_frame(5, -1, 0, 0, 32'hC0, 0, 0);
    rstn = 0; axis.TVALID = 1; axis.TDATA = 32'hBAD0_0006;
    tick();
    check_eq("rst_mid_busy", busy, 0);
    check_eq("rst_mid_count", wr_count, 0);
    rstn = 1; axis.TVALID = 0; cap_en = 0;
    tick();
    rd_check("rst_discard_a5", 5, 37);
    rd_check("rearm_a0", 0, 32'hC0);

    // Read-first on a same-address collision
    arm(0);
    send_frame(4, 3, 0, 0, 32'hA7, 0, 0);
    idle_off();
    arm(0);
    send_frame(3, -1, 0, 0, 32'h50, 0, 0);
    rd_seen.delete(); rd_seen_cyc.delete();
    axis.TVALID = 1; axis.TDATA = 32'h55; axis.TLAST = 1; rd_en = 1; rd_addr = 3;
    tick();
    axis.TVALID = 0; axis.TLAST = 0;
    tick();
    rd_en = 0;
    tick(); tick();
    check_eq("rf_cnt", rd_seen.size(), 2);
    if (rd_seen.size() == 2) begin
      check_eq("rf_old", rd_seen[0], 32'hAA);
      check_eq("rf_new", rd_seen[1], 32'h55);
    end
    idle_off();

    // Randomized sessions
    for (int it = 0; it < 40; it++) begin
      int len, last;
      len  = $urandom_range(1, 45);
      last = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, len - 1));
      arm(1'($urandom_range(0, 1)));
      send_frame(len, last, 1'($urandom_range(0, 1)), 1, '0,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      for (int k = 0; k < 3; k++) begin
        rd_en = 1'($urandom_range(0, 1));
        rd_addr = AW'($urandom_range(0, DEPTH - 1));
        tick();
      end
      rd_en = 0;
      idle_off();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/axis_tcm_capture.md
Name: axis_tcm_capture

Overview:
- Parametrised AXI-Stream slave that captures one stream frame into an inferred TCM BRAM.
- Successor to the fixed 32x32 AXIS-to-TCM block: generic data width and depth; one-shot and circular capture modes; TLAST framing; status/count outputs; an independent read port that is never blocked by writes.
- Sits between a DMA/stream source and the AXI-Lite register block; control and status map to slave registers.

Parameters:
C_S_AXIS_TDATA_WIDTH, 32, stream data width and BRAM word width.
C_TCM_ADDR_WIDTH, 5, BRAM address width; DEPTH = 2**C_TCM_ADDR_WIDTH words.

Ports:
S_AXIS_ACLK  in  1  single clock; all logic on its rising edge.
S_AXIS_ARESETN  in  1  reset, synchronous, active-low.
S_AXIS_TREADY  out  1  slave ready.
S_AXIS_TDATA  in  C_S_AXIS_TDATA_WIDTH  stream data.
S_AXIS_TLAST  in  1  end of frame.
S_AXIS_TVALID  in  1  stream valid.
USR_cap_en  in  1  level; 1 arms/holds capture, 0 aborts or idles.
USR_cap_mode  in  1  0 = one-shot, 1 = circular; sampled on IDLE->CAPTURE only.
USR_clear  in  1  pulse; clears status and returns to IDLE.
USR_rd_en  in  1  read strobe.
USR_rd_addr  in  C_TCM_ADDR_WIDTH  read address.
USR_rd_data  out  C_S_AXIS_TDATA_WIDTH  read data.
USR_rd_valid  out  1  USR_rd_data valid this cycle.
USR_wr_count  out  C_TCM_ADDR_WIDTH+1  words captured, saturating at DEPTH.
USR_wr_ptr  out  C_TCM_ADDR_WIDTH  next write address (oldest word in circular mode after wrap).
USR_busy  out  1  state == CAPTURE.
USR_done  out  1  frame completed (TLAST or full).
USR_trunc  out  1  one-shot stopped at full without TLAST.
USR_wrapped  out  1  circular mode overwrote at least one word.

Behaviour:
- Reset (S_AXIS_ARESETN=0 at a clock edge): state IDLE; TREADY, rd_valid, busy, done, trunc, wrapped = 0; wr_count = 0; wr_ptr = 0; rd_data = 0. BRAM contents are not reset. Reset mid-capture discards the in-flight beat.
- Priority each cycle: reset > USR_clear > FSM.
- USR_clear: state IDLE; wr_count, wr_ptr, done, trunc, wrapped = 0; BRAM untouched.
- Beat = TVALID & TREADY. TREADY is registered and equals (next state == CAPTURE), so it is 1 exactly while in CAPTURE. TDATA is never latched without TREADY.
- FSM:
  - IDLE: cap_en=1 -> CAPTURE; latch mode; wr_ptr = 0; wr_count = 0; flags cleared.
  - CAPTURE: each beat writes TDATA to mem[wr_ptr] at that edge (no extra buffer stage); wr_ptr += 1 (mod DEPTH); wr_count += 1, saturating at DEPTH.
    - Beat with TLAST -> DONE; done = 1.
    - One-shot, beat making wr_count == DEPTH without TLAST -> DONE; done = 1; trunc = 1. TREADY is 0 the next cycle.
    - Circular: wr_ptr wraps 31->0 for default depth; the first write while wr_count == DEPTH sets wrapped = 1. Only TLAST ends the capture.
    - TLAST on the final free word in one-shot -> done = 1, trunc = 0.
    - cap_en=0 -> IDLE; a beat in the same cycle is still accepted. done = 0; count and data are retained.
  - DONE: TREADY = 0; holds until USR_clear, or cap_en=0 -> IDLE (status retained until the next arm).
- Read port: independent of writes. rd_en at edge N -> rd_data = mem[rd_addr], rd_valid = 1 at edge N+1. rd_valid = 0 otherwise; rd_data holds its last value.
- Same-address read and write in one cycle: read-first (returns old data).

Optional Feature:
- Macro AXIS_TCM_RD_PIPE_EN.
- Defined: an extra output register on the read path; latency 2 (rd_en at N -> rd_data/rd_valid at N+2). Back-to-back reads are fully pipelined.
- Undefined: latency 1 as above.
- Reset clears the pipeline valid bit in both builds.

Test Plan:
- One-shot, 4 beats 0xA0..0xA3, TLAST on the 4th, TVALID continuous -> TREADY drops the cycle after beat 4; done=1, trunc=0, wr_count=4; reads 0..3 return 0xA0..0xA3, rd_valid 1 cycle after rd_en (2 with AXIS_TCM_RD_PIPE_EN).
- One-shot, 40 beats no TLAST, depth 32 -> exactly 32 accepted; done=1, trunc=1, wr_count=32; addr 31 = beat 31.
- Circular, 40 beats 0..39, TLAST on 39 -> wrapped=1, wr_count=32, wr_ptr=8; addr 7 = 39, addr 8 = 8.
- TVALID toggling 1/0 with beats 0x11,0x22,0x33 -> only valid beats stored, at consecutive addresses 0,1,2.
- Mid-capture: cap_en=0 after 5 beats -> IDLE, TREADY=0, wr_count=5. Re-arm -> wr_count=0, new data from addr 0. Reset asserted during beat 6 -> all outputs at reset values next cycle.
- Write mem[3]=0x55 while rd_en on addr 3 (old 0xAA) -> rd_data=0xAA; a read the next cycle returns 0x55.
